pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 114 +++++++++++
 tb/tb_pipe_stage_reg.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a head entry plus an optional skid entry.
// Supports stall (hazard hold), flush (kill) and a saturating count of flushed beats.
module pipe_stage_reg #(
    parameter int                 DATA_W      = 128,
    parameter int                 CTRL_W      = 16,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = {CTRL_W{1'b0}},
    parameter bit                 SKID_EN     = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [7:0]        drop_cnt
);

    logic              head_v_q, head_v_d;
    logic              skid_v_q, skid_v_d;
    logic [CTRL_W-1:0] head_c_q, head_c_d;
    logic [CTRL_W-1:0] skid_c_q, skid_c_d;
    logic [DATA_W-1:0] head_d_q, head_d_d;
    logic [DATA_W-1:0] skid_d_q, skid_d_d;
    logic [7:0]        drop_q, drop_d;
    logic              rdy_en_q;
    logic              accept_s;
    logic              emit_s;
    logic [8:0]        drop_sum_s;

    // rdy_en_q keeps in_ready low through reset and lets it rise on the first edge after.
    assign in_ready  = SKID_EN ? (rdy_en_q & ~skid_v_q & ~stall)
                               : (rdy_en_q & (~head_v_q | out_ready) & ~stall);
    assign out_valid = head_v_q & ~stall;
    assign out_ctrl  = out_valid ? head_c_q : CTRL_BUBBLE;
    assign out_data  = head_d_q;
    assign occupancy = {1'b0, head_v_q} + {1'b0, skid_v_q};
    assign drop_cnt  = drop_q;
    assign accept_s  = in_valid & in_ready;
    assign emit_s    = out_valid & out_ready;

    // Beats lost on a flush: held entries plus the accepted beat, minus a head taken downstream.
    assign drop_sum_s = {1'b0, drop_q} + {8'b0, head_v_q} + {8'b0, skid_v_q}
                      + {8'b0, accept_s} - {8'b0, emit_s};

    // Next-state selection for the entries and the drop counter.
    always_comb begin
        head_v_d = head_v_q;
        skid_v_d = skid_v_q;
        head_c_d = head_c_q;
        skid_c_d = skid_c_q;
        head_d_d = head_d_q;
        skid_d_d = skid_d_q;
        drop_d   = drop_q;
        if (flush) begin
            head_v_d = 1'b0;
            skid_v_d = 1'b0;
            head_c_d = CTRL_BUBBLE;
            skid_c_d = CTRL_BUBBLE;
            drop_d   = drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
        end else if (stall) begin
            drop_d = drop_q;
        end else if (emit_s || !head_v_q) begin
            if (skid_v_q) begin
                head_v_d = 1'b1;
                head_c_d = skid_c_q;
                head_d_d = skid_d_q;
                skid_v_d = accept_s;
                skid_c_d = accept_s ? in_ctrl : CTRL_BUBBLE;
                skid_d_d = accept_s ? in_data : skid_d_q;
            end else begin
                head_v_d = accept_s;
                head_c_d = accept_s ? in_ctrl : CTRL_BUBBLE;
                head_d_d = accept_s ? in_data : head_d_q;
            end
        end else if (accept_s && SKID_EN) begin
            skid_v_d = 1'b1;
            skid_c_d = in_ctrl;
            skid_d_d = in_data;
        end else begin
            skid_v_d = skid_v_q;
        end
    end

    // State registers, asynchronously cleared.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            head_c_q <= CTRL_BUBBLE;
            skid_c_q <= CTRL_BUBBLE;
            head_d_q <= {DATA_W{1'b0}};
            skid_d_q <= {DATA_W{1'b0}};
            drop_q   <= 8'd0;
            rdy_en_q <= 1'b0;
        end else begin
            head_v_q <= head_v_d;
            skid_v_q <= skid_v_d;
            head_c_q <= head_c_d;
            skid_c_q <= skid_c_d;
            head_d_q <= head_d_d;
            skid_d_q <= skid_d_d;
            drop_q   <= drop_d;
            rdy_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized scoreboard bench driving a skid (index 0) and a single-entry (index 1)
// instance of pipe_stage_reg with shared stimulus.
module tb_pipe_stage_reg;

    localparam int              DW     = 128;
    localparam int              CW     = 16;
    localparam logic [CW-1:0]   BUBBLE = 16'hDEAD;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;

    logic          rdy [2];
    logic          ov  [2];
    logic [CW-1:0] oc  [2];
    logic [DW-1:0] od  [2];
    logic [1:0]    occ [2];
    logic [7:0]    drp [2];

    beat_t sb [2][$];
    int    drop [2];
    bit    post_rst = 1'b0;
    int    ncheck = 0;
    int    nfail  = 0;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUBBLE), .SKID_EN(1'b1)) u_skid (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready),
        .out_ctrl(oc[0]), .out_data(od[0]), .stall(stall), .flush(flush),
        .occupancy(occ[0]), .drop_cnt(drp[0])
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUBBLE), .SKID_EN(1'b0)) u_noskid (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready),
        .out_ctrl(oc[1]), .out_data(od[1]), .stall(stall), .flush(flush),
        .occupancy(occ[1]), .drop_cnt(drp[1])
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        ncheck++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic step(input int pv, input int pr, input int ps, input int pf, input logic rn);
        int  cnt;
        int  d;
        bit  er, eov, acc, emit;
        beat_t b;
        @(negedge clock);
        #1;
        reset_n   = rn;
        in_valid  = ($urandom_range(99) < pv);
        in_ctrl   = CW'($urandom);
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        out_ready = ($urandom_range(99) < pr);
        stall     = ($urandom_range(99) < ps);
        flush     = ($urandom_range(99) < pf);
        #1;
        if (!rn) begin
            sb[0].delete();
            sb[1].delete();
            drop[0]  = 0;
            drop[1]  = 0;
            post_rst = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            cnt = sb[k].size();
            if (k == 0) er = rn && post_rst && !stall && (cnt < 2);
            else        er = rn && post_rst && !stall && (cnt == 0 || out_ready);
            eov = rn && (cnt > 0) && !stall;
            chk($sformatf("dut%0d in_ready", k),  DW'(rdy[k]), DW'(er));
            chk($sformatf("dut%0d out_valid", k), DW'(ov[k]),  DW'(eov));
            chk($sformatf("dut%0d occupancy", k), DW'(occ[k]), DW'(cnt));
            chk($sformatf("dut%0d drop_cnt", k),  DW'(drp[k]), DW'(drop[k]));
            if (!eov) chk($sformatf("dut%0d bubble ctrl", k), DW'(oc[k]), DW'(BUBBLE));
            if (rn) begin
                acc  = in_valid && er;
                emit = eov && out_ready;
                if (flush) begin
                    d = drop[k] + cnt + int'(acc) - int'(emit);
                    drop[k] = (d > 255) ? 255 : d;
                    if (emit) begin
                        while (sb[k].size() > 1) void'(sb[k].pop_back());
                    end else begin
                        sb[k].delete();
                    end
                end else if (!stall && acc) begin
                    b.c = in_ctrl;
                    b.d = in_data;
                    sb[k].push_back(b);
                end
            end
        end
        if (rn) post_rst = 1'b1;
    endtask

    // Monitor: every beat the DUT hands downstream must be the oldest expected one.
    initial begin
        beat_t b;
        forever begin
            @(negedge clock);
            #3;
            for (int k = 0; k < 2; k++) begin
                if (reset_n && ov[k] && out_ready) begin
                    if (sb[k].size() == 0) begin
                        ncheck++;
                        nfail++;
                        $display("FAIL dut%0d unexpected beat: got %0h expected none", k, od[k]);
                    end else begin
                        b = sb[k].pop_front();
                        chk($sformatf("dut%0d out_data", k), od[k], b.d);
                        chk($sformatf("dut%0d out_ctrl", k), DW'(oc[k]), DW'(b.c));
                    end
                end
            end
        end
    end

    initial begin
        repeat (3)    step(0, 0, 0, 0, 1'b0);
        repeat (20)   step(100, 100, 0, 0, 1'b1);
        repeat (5)    step(100, 0, 0, 0, 1'b1);
        repeat (6)    step(100, 100, 0, 0, 1'b1);
        repeat (150)  step(50, 70, 40, 0, 1'b1);
        repeat (1500) step(70, 60, 15, 8, ($urandom_range(299) != 0));
        repeat (10)   step(100, 100, 0, 0, 1'b1);
        repeat (2)    step(100, 100, 0, 0, 1'b0);
        repeat (10)   step(100, 80, 0, 0, 1'b1);
        repeat (700)  step(100, 30, 5, 50, 1'b1);
        for (int k = 0; k < 2; k++) chk($sformatf("dut%0d saturated", k), DW'(drp[k]), DW'(255));
        repeat (50)   step(100, 30, 0, 40, 1'b1);
        repeat (8)    step(0, 100, 0, 0, 1'b1);
        @(negedge clock);
        #5;
        for (int k = 0; k < 2; k++) chk($sformatf("dut%0d drained", k), DW'(sb[k].size()), DW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
        $finish;
    end

endmodule
